cp0_gen2: RTL

CP0_GEN2 -- requirements
Module: cp0_gen2

---
 rtl/cp0_pkg.sv | 45 ++++
 rtl/cp0_timer.sv | 50 +++++
 rtl/cp0_gen2.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/cp0_pkg.sv
// ============================================================================
// Module      : cp0_pkg
// Description : Shared constants for the CP0 block: register numbers, SR and
//               Cause field positions, and the architectural ExcCode values.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cp0_pkg;

    // mfc0/mtc0 register numbers
    localparam logic [4:0] c_reg_count   = 5'd9;
    localparam logic [4:0] c_reg_compare = 5'd11;
    localparam logic [4:0] c_reg_sr      = 5'd12;
    localparam logic [4:0] c_reg_cause   = 5'd13;
    localparam logic [4:0] c_reg_epc     = 5'd14;
    localparam logic [4:0] c_reg_prid    = 5'd15;

    // SR field positions
    localparam int c_sr_ie     = 0;
    localparam int c_sr_exl    = 1;
    localparam int c_sr_im_lsb = 10;

    // Cause field positions
    localparam int c_cause_exc_lsb = 2;
    localparam int c_cause_ip_lsb  = 10;
    localparam int c_cause_ti      = 30;
    localparam int c_cause_bd      = 31;

    // Width of the IP/IM fields and the word-alignment mask for PCs
    localparam int          c_ip_w      = 6;
    localparam logic [31:0] c_word_mask = 32'hFFFF_FFFC;

    // Architectural exception codes
    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

endpackage

`default_nettype wire

// File: rtl/cp0_timer.sv
// ============================================================================
// Module      : cp0_timer
// Description : Count/Compare timer. Count free-runs, TI latches when the
//               pre-increment Count hits a non-zero Compare and is cleared
//               only by software writing Compare.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cp0_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_wr_count,
    input  logic        i_wr_compare,
    input  logic [31:0] i_wd,
    output logic [31:0] o_count,
    output logic [31:0] o_compare,
    output logic        o_ti
);

    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_ti;

    // Count/Compare/TI update; a Compare write wins over a same-cycle match
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count   <= '0;
            r_compare <= '0;
            r_ti      <= 1'b0;
        end else begin
            r_count <= i_wr_count ? i_wd : r_count + 32'd1;
            if (i_wr_compare) begin
                r_compare <= i_wd;
            end
            if (i_wr_compare) begin
                r_ti <= 1'b0;
            end else if ((r_count == r_compare) && (r_compare != 32'd0)) begin
                r_ti <= 1'b1;
            end
        end
    end

    assign o_count   = r_count;
    assign o_compare = r_compare;
    assign o_ti      = r_ti;

endmodule

`default_nettype wire

// File: rtl/cp0_gen2.sv
// ============================================================================
// Module      : cp0_gen2
// Description : Minimal MIPS-style coprocessor 0: SR, Cause, EPC, PRId and an
//               optional Count/Compare timer, with exception entry/eret and
//               a level-sensitive interrupt request.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cp0_gen2
    import cp0_pkg::*;
#(
    parameter int          NUM_HWINT  = 6,
    parameter int          HAS_TIMER  = 1,
    parameter int          TIMER_LINE = 5,
    parameter logic [31:0] PRID       = 32'h0000_0001
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           addr,
    input  logic [31:0]          wd,
    input  logic                 we,
    output logic [31:0]          rd,
    input  logic                 exc_we,
    input  logic                 exc_bd,
    input  logic [4:0]           exc_code,
    input  logic [31:0]          exc_pc,
    input  logic                 eret,
    input  logic [NUM_HWINT-1:0] hwint,
    output logic [31:0]          epc_out,
    output logic [31:0]          sr_out,
    output logic                 irq
);

    logic [c_ip_w-1:0] r_im;
    logic [c_ip_w-1:0] r_ip;
    logic              r_exl;
    logic              r_ie;
    logic              r_bd;
    logic [4:0]        r_exc_code;
    logic [31:0]       r_epc;

    logic              w_mtc0;
    logic [31:0]       w_count;
    logic [31:0]       w_compare;
    logic              w_ti;
    logic [c_ip_w-1:0] w_ip_next;
    logic [31:0]       w_sr;
    logic [31:0]       w_cause;

    // Exception entry and eret both pre-empt a same-cycle mtc0
    assign w_mtc0 = we & ~exc_we & ~eret;

    generate
        if (HAS_TIMER != 0) begin : g_timer
            cp0_timer u_timer (
                .clk          (clk),
                .reset        (reset),
                .i_wr_count   (w_mtc0 && (addr == c_reg_count)),
                .i_wr_compare (w_mtc0 && (addr == c_reg_compare)),
                .i_wd         (wd),
                .o_count      (w_count),
                .o_compare    (w_compare),
                .o_ti         (w_ti)
            );
        end else begin : g_no_timer
            assign w_count   = '0;
            assign w_compare = '0;
            assign w_ti      = 1'b0;
        end
    endgenerate

    // Next pending-interrupt vector: raw hardware lines plus the timer line
    always_comb begin
        w_ip_next = '0;
        for (int i = 0; i < NUM_HWINT; i++) begin
            w_ip_next[i] = hwint[i];
        end
        w_ip_next[TIMER_LINE] = w_ip_next[TIMER_LINE] | w_ti;
    end

    // Assemble the architectural SR and Cause words from their fields
    always_comb begin
        w_sr                                   = '0;
        w_sr[c_sr_im_lsb +: c_ip_w]            = r_im;
        w_sr[c_sr_exl]                         = r_exl;
        w_sr[c_sr_ie]                          = r_ie;
        w_cause                                = '0;
        w_cause[c_cause_bd]                    = r_bd;
        w_cause[c_cause_ti]                    = w_ti;
        w_cause[c_cause_ip_lsb +: c_ip_w]      = r_ip;
        w_cause[c_cause_exc_lsb +: 5]          = r_exc_code;
    end

    // mfc0 read mux; unimplemented registers read as zero
    always_comb begin
        case (addr)
            c_reg_count:   rd = w_count;
            c_reg_compare: rd = w_compare;
            c_reg_sr:      rd = w_sr;
            c_reg_cause:   rd = w_cause;
            c_reg_epc:     rd = r_epc;
            c_reg_prid:    rd = PRID;
            default:       rd = '0;
        endcase
    end

    // SR/Cause/EPC update with priority reset > exception > eret > mtc0
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_im       <= '0;
            r_ip       <= '0;
            r_exl      <= 1'b1;
            r_ie       <= 1'b0;
            r_bd       <= 1'b0;
            r_exc_code <= '0;
            r_epc      <= '0;
        end else begin
            r_ip <= w_ip_next;
            if (exc_we) begin
                r_exc_code <= exc_code;
                // A nested entry keeps the original return context
                if (!r_exl) begin
                    r_exl <= 1'b1;
                    r_bd  <= exc_bd;
                    r_epc <= (exc_pc & c_word_mask) - (exc_bd ? 32'd4 : 32'd0);
                end
            end else if (eret) begin
                r_exl <= 1'b0;
            end else if (we) begin
                case (addr)
                    c_reg_sr: begin
                        r_im  <= wd[c_sr_im_lsb +: c_ip_w];
                        r_exl <= wd[c_sr_exl];
                        r_ie  <= wd[c_sr_ie];
                    end
                    c_reg_epc: r_epc <= wd & c_word_mask;
                    default:   ;
                endcase
            end
        end
    end

    assign irq     = r_ie & ~r_exl & (|(r_ip & r_im));
    assign epc_out = r_epc;
    assign sr_out  = w_sr;

endmodule

`default_nettype wire
